// File: rtl/icache_refill_axi.sv
// AXI4 read refill engine for the two-way instruction cache: one INCR burst per miss,
// assembles the beats into a cache line and presents it with a single-cycle refresh.
module icache_refill_axi #(
    parameter int LINE_W = 64,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 64,
    parameter int AXI_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ack,
    output logic              busy,
    output logic              refresh,
    output logic [LINE_W-1:0] cacheline_new,
    output logic              refill_err,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [3:0]        arid,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic [3:0]        rid
);
    localparam int BEATS = LINE_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             beat;
    logic             last_beat;
    logic             beat_bad;

    assign beat      = (state == DATA) && rvalid;
    assign last_beat = (cnt == LAST_CNT);
    // A beat is bad on an error response, a foreign ID, or rlast disagreeing with our own count.
    assign beat_bad  = (rresp != 2'b00) || (rid != 4'(AXI_ID)) || (rlast != last_beat);

    assign arlen   = 8'(BEATS - 1);
    assign arsize  = 3'($clog2(DATA_W / 8));
    assign arburst = 2'b01;
    assign arid    = 4'(AXI_ID);

    // NOTE: every state element uses non-blocking assignment so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: next state is defaulted before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (miss_req)            state_next = ADDR;
            ADDR: if (arready)             state_next = DATA;
            DATA: if (beat && last_beat)   state_next = DONE;
            DONE:                          state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    assign miss_ack   = !rst && (state == IDLE) && miss_req;
    assign busy       = (state != IDLE);
    assign arvalid    = (state == ADDR);
    assign rready     = (state == DATA);
    assign refresh    = (state == DONE) && !err;
    assign refill_err = (state == DONE) && err;

    // NOTE: the line buffer is an ordinary register, so it is cleared by reset like any other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            araddr        <= '0;
            cacheline_new <= '0;
            cnt           <= '0;
            err           <= 1'b0;
        end else begin
            if (state == IDLE && miss_req) begin
                araddr <= miss_addr & ~OFF_MASK;
                cnt    <= '0;
                err    <= 1'b0;
            end
            if (beat) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (cnt == CNT_W'(b)) cacheline_new[b*DATA_W +: DATA_W] <= rdata;
                end
                cnt <= cnt + CNT_W'(1);
                if (beat_bad) err <= 1'b1;
            end
        end
    end
endmodule
